// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : seg7_pkg                                                      |
// | Purpose    : Shared constants and decode helper for the 7-segment scan     |
// |              driver: active-low segment patterns {a,b,c,d,e,f,g} (bit6=a,  |
// |              bit0=g), digit-code width, slot pattern type and the          |
// |              code-to-segment decode function.                              |
// | Ports      : none (package)                                               |
// | Revision   : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  // Width of one packed digit code.
  localparam int DIGIT_W = 4;

  // Active-low segment patterns, bit6 = a ... bit0 = g, 0 = segment lit.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Pattern held on the segment bus for one digit slot (both fields active-low).
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg7_pat_t;

  localparam seg7_pat_t PAT_BLANK = '{seg: SEG_BLANK, dp: 1'b1};

  // Map a 4-bit digit code to its active-low pattern. Codes 10-15 render
  // as hex letters only when hex_en is set; otherwise they go dark.
  function automatic logic [6:0] seg7_decode(input logic [DIGIT_W-1:0] code,
                                             input logic               hex_en);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB:    seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC:    seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD:    seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE:    seg = hex_en ? SEG_E : SEG_BLANK;
      4'hF:    seg = hex_en ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seg7_hex_decode                                               |
// | Purpose    : Purely combinational digit-code to 7-segment decoder.         |
// | Parameters : HEX_EN - 1: codes 10-15 show A b C d E F; 0: they are blank   |
// | Ports      : code [3:0] in  - digit code                                  |
// |              seg  [6:0] out - active-low pattern {a..g}, bit6 = a          |
// | Revision   : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  localparam logic C_HEX_EN = (HEX_EN != 0);

  assign seg = seg7_decode(code, C_HEX_EN);

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seg7_scan_driver                                              |
// | Purpose    : Multiplexed N-digit 7-segment display driver. Captures packed |
// |              digit codes on a load strobe and time-multiplexes them onto   |
// |              a shared active-low segment bus with per-digit active-low     |
// |              anodes, dead time, leading-zero blanking and a frame pulse.   |
// | Parameters : NUM_DIGITS (1..8), CLK_DIV (>= BLANK_CYC+2), BLANK_CYC,       |
// |              HEX_EN                                                        |
// | Ports      : clk        in  system clock                                   |
// |              rst_n      in  synchronous active-low reset                   |
// |              enable     in  1 = scanning, 0 = dark with scan state frozen  |
// |              load       in  strobe capturing digits_in/dp_in               |
// |              digits_in  in  4 bits per digit, [3:0] = digit 0 (rightmost)  |
// |              dp_in      in  decimal point request per digit, 1 = lit       |
// |              blank_lz   in  leading-zero blanking enable (live)            |
// |              seg_n      out segments {a..g}, bit6 = a, 0 = lit             |
// |              dp_n       out decimal point of active digit, 0 = lit         |
// |              an_n       out anode enables, 0 = driven, at most one low     |
// |              frame_done out one-cycle pulse after the last slot completes  |
// | Revision   : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int HEX_EN     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          frame_done
);

  // Counter widths are kept at least one bit so NUM_DIGITS=1 still elaborates;
  // in that case idx simply never leaves 0.
  localparam int C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [C_CNT_W-1:0] C_CNT_MAX   = C_CNT_W'(CLK_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_BLANK = C_CNT_W'(BLANK_CYC);
  localparam logic [C_IDX_W-1:0] C_IDX_MAX   = C_IDX_W'(NUM_DIGITS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_CNT_W-1:0]            cnt_q,        cnt_d;
  logic [C_IDX_W-1:0]            idx_q,        idx_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_q,     digits_d;
  logic [NUM_DIGITS-1:0]         dp_sh_q,      dp_sh_d;
  seg7_pat_t                     pat_q,        pat_d;
  logic [NUM_DIGITS-1:0]         an_n_q,       an_n_d;
  logic                          frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_mask;     // 1 = digit is a blanked leading zero
  logic                  zero_run;
  logic [DIGIT_W-1:0]    sel_code;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] an_sel_n;    // one-cold anode pattern for idx_q
  logic [6:0]            dec_seg;
  seg7_pat_t             slot_pat;
  logic                  cnt_last;
  logic                  idx_last;

  // Walk from the most significant digit down; a digit is a leading zero
  // only while every digit above it is also zero. Digit 0 is never masked
  // so a zero value still shows a single "0".
  always_comb begin
    zero_run = blank_lz;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (digits_q[i*DIGIT_W +: DIGIT_W] == '0);
      lz_mask[i] = zero_run;
    end
  end

  // Select the shadow entry belonging to the current slot. A compare-per-digit
  // mux avoids out-of-range indexing when NUM_DIGITS is not a power of two.
  always_comb begin
    sel_code  = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_sel_n  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == C_IDX_W'(i)) begin
        sel_code    = digits_q[i*DIGIT_W +: DIGIT_W];
        sel_dp      = dp_sh_q[i];
        sel_blank   = lz_mask[i];
        an_sel_n[i] = 1'b0;
      end
    end
  end

  seg7_hex_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .code (sel_code),
    .seg  (dec_seg)
  );

  // Decimal point follows dp_in even on a blanked leading zero.
  always_comb begin
    slot_pat.seg = sel_blank ? SEG_BLANK : dec_seg;
    slot_pat.dp  = ~sel_dp;
  end

  assign cnt_last = (cnt_q == C_CNT_MAX);
  assign idx_last = (idx_q == C_IDX_MAX);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    digits_d     = digits_q;
    dp_sh_d      = dp_sh_q;
    pat_d        = pat_q;
    an_n_d       = '1;
    frame_done_d = 1'b0;

    // Shadow capture runs regardless of enable.
    if (load) begin
      digits_d = digits_in;
      dp_sh_d  = dp_in;
    end

    if (enable) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;

      if (cnt_last) begin
        idx_d        = idx_last ? '0 : idx_q + 1'b1;
        frame_done_d = idx_last;
      end

      // The pattern is latched only at slot start, so a load arriving
      // mid-slot cannot disturb the digit currently on the bus.
      if (cnt_q == '0) begin
        pat_d = slot_pat;
      end

      // Anodes stay off for the first BLANK_CYC cycles of each slot so the
      // previous digit's segments do not ghost onto the new one.
      if (cnt_q >= C_CNT_BLANK) begin
        an_n_d = an_sel_n;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      digits_q     <= '0;
      dp_sh_q      <= '0;
      pat_q        <= PAT_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      digits_q     <= digits_d;
      dp_sh_q      <= dp_sh_d;
      pat_q        <= pat_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = pat_q.seg;
  assign dp_n       = pat_q.dp;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule : seg7_scan_driver
`default_nettype wire
